// File: rtl/mult_arb_pkg.sv
// ----------------------------------------------------------------------------
// mult_arb_pkg
// Shared types and constants for the two-requester multiplier arbiter.
//   state_e        : arbiter FSM states
//   DATA_W / RES_W : operand width (8) and product width (16)
//   MUL_CYCLES_DEF : default number of cycles Run is held per operation
// ----------------------------------------------------------------------------
package mult_arb_pkg;

    localparam int unsigned DATA_W         = 8;
    localparam int unsigned RES_W          = 16;
    localparam int unsigned MUL_CYCLES_DEF = 18;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOADB      = 3'd1,
        LOADB_WAIT = 3'd2,
        RUN        = 3'd3,
        RELEASE    = 3'd4
    } state_e;

endpackage

// File: rtl/mult_arbiter_if.sv
// ----------------------------------------------------------------------------
// mult_arbiter_if
// Bundles the requester side and the multiplier-datapath side of the arbiter.
//   req               : per-requester request level (bit i = requester i)
//   a0/b0, a1/b1      : multiplicand / multiplier per requester
//   gnt               : one-hot grant, held for the whole operation
//   done              : one-cycle pulse to the granted requester
//   result            : signed product, held until the next capture
//   mul_Sw            : switch value presented to the multiplier datapath
//   mul_ClearA_LoadB  : clear A / load B strobe
//   mul_Run           : run strobe
//   mul_Aval/mul_Bval : upper / lower product halves from the datapath
// Modports: slave = arbiter, master = requesters plus multiplier datapath.
// ----------------------------------------------------------------------------
interface mult_arbiter_if;
    import mult_arb_pkg::*;

    logic [1:0]        req;
    logic [DATA_W-1:0] a0;
    logic [DATA_W-1:0] b0;
    logic [DATA_W-1:0] a1;
    logic [DATA_W-1:0] b1;
    logic [1:0]        gnt;
    logic [1:0]        done;
    logic [RES_W-1:0]  result;
    logic [DATA_W-1:0] mul_Sw;
    logic              mul_ClearA_LoadB;
    logic              mul_Run;
    logic [DATA_W-1:0] mul_Aval;
    logic [DATA_W-1:0] mul_Bval;

    modport slave (
        input  req, a0, b0, a1, b1, mul_Aval, mul_Bval,
        output gnt, done, result, mul_Sw, mul_ClearA_LoadB, mul_Run
    );

    modport master (
        output req, a0, b0, a1, b1, mul_Aval, mul_Bval,
        input  gnt, done, result, mul_Sw, mul_ClearA_LoadB, mul_Run
    );

endinterface

// File: rtl/mult_arb_grant.sv
// ----------------------------------------------------------------------------
// mult_arb_grant
// Combinational winner selection between two requesters.
//   i_req : request vector
//   i_ptr : index of the requester served last
//   o_win : one-hot winner (0 when nobody requests)
// Build option MULT_ARB_RR_EN: round-robin tie-break using i_ptr.
// Default: fixed priority, requester 0 wins every tie and i_ptr is ignored.
// ----------------------------------------------------------------------------
module mult_arb_grant (
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_win
);

`ifdef MULT_ARB_RR_EN
    always_comb begin
        o_win = 2'b00;
        if (i_req == 2'b11) begin
            // Tie: the requester that was not served last wins.
            o_win = i_ptr ? 2'b01 : 2'b10;
        end else begin
            o_win = i_req;
        end
    end
`else
    logic w_unused_ptr;
    assign w_unused_ptr = i_ptr;

    always_comb begin
        o_win = 2'b00;
        if (i_req[0]) begin
            o_win = 2'b01;
        end else if (i_req[1]) begin
            o_win = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/mult_arbiter.sv
// ----------------------------------------------------------------------------
// mult_arbiter
// Shares one sequential multiplier datapath between two requesters.
// Per operation: LOADB (load multiplier b), LOADB_WAIT, RUN for MUL_CYCLES
// cycles with the multiplicand a on mul_Sw, then RELEASE with a done pulse.
// The product {mul_Aval, mul_Bval} is captured on the edge ending RUN.
//   Clk   : system clock, rising edge
//   Reset : synchronous, active-high
//   bus   : mult_arbiter_if.slave (requests, operands, grant, done, result,
//           multiplier datapath controls and product halves)
// Build option MULT_ARB_RR_EN: round-robin tie-break with a last-served
// pointer; otherwise fixed priority to requester 0 and no pointer register.
// ----------------------------------------------------------------------------
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF
) (
    input  logic          Clk,
    input  logic          Reset,
    mult_arbiter_if.slave bus
);

    localparam int unsigned CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    state_e            r_state;
    state_e            w_next_state;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_idx;
    logic [CNT_W-1:0]  r_cnt;
    logic [RES_W-1:0]  r_result;
    logic [1:0]        w_win;
    logic              w_ptr;
    logic              w_start;
    logic              w_run_last;
    logic [1:0]        w_onehot;

    logic [1:0]        w_gnt;
    logic [1:0]        w_done;
    logic [DATA_W-1:0] w_sw;
    logic              w_clr_ldb;
    logic              w_run;

    assign w_start    = (r_state == IDLE) && (bus.req != 2'b00);
    assign w_run_last = (r_cnt == CNT_W'(MUL_CYCLES - 1));
    assign w_onehot   = r_idx ? 2'b10 : 2'b01;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef MULT_ARB_RR_EN
    logic r_last;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_last <= 1'b1;  // requester 0 wins the first tie
        end else if (w_start) begin
            r_last <= w_win[1];
        end
    end

    assign w_ptr = r_last;
`else
    assign w_ptr = 1'b1;
`endif

    mult_arb_grant u_grant (
        .i_req (bus.req),
        .i_ptr (w_ptr),
        .o_win (w_win)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:       if (w_start) w_next_state = LOADB;
            LOADB:      w_next_state = LOADB_WAIT;
            LOADB_WAIT: w_next_state = RUN;
            RUN:        if (w_run_last) w_next_state = RELEASE;
            RELEASE:    w_next_state = IDLE;
            default:    w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt     = 2'b00;
        w_done    = 2'b00;
        w_sw      = '0;
        w_clr_ldb = 1'b0;
        w_run     = 1'b0;
        unique case (r_state)
            IDLE: begin
            end
            LOADB: begin
                w_gnt     = w_onehot;
                w_sw      = r_b;
                w_clr_ldb = 1'b1;
            end
            LOADB_WAIT: begin
                w_gnt = w_onehot;
                w_sw  = r_b;
            end
            RUN: begin
                w_gnt = w_onehot;
                w_sw  = r_a;
                w_run = 1'b1;
            end
            RELEASE: begin
                w_gnt  = w_onehot;
                w_done = w_onehot;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand latch, RUN counter, result capture
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_idx <= 1'b0;
        end else if (w_start) begin
            // Operands are sampled only here; later changes are ignored.
            r_idx <= w_win[1];
            r_a   <= w_win[1] ? bus.a1 : bus.a0;
            r_b   <= w_win[1] ? bus.b1 : bus.b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cnt <= '0;
        end else if (r_state == LOADB_WAIT) begin
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_result <= '0;
        end else if ((r_state == RUN) && w_run_last) begin
            r_result <= {bus.mul_Aval, bus.mul_Bval};
        end
    end

    assign bus.gnt              = w_gnt;
    assign bus.done             = w_done;
    assign bus.result           = r_result;
    assign bus.mul_Sw           = w_sw;
    assign bus.mul_ClearA_LoadB = w_clr_ldb;
    assign bus.mul_Run          = w_run;

endmodule

// File: tb/tb_mult_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mult_arbiter
// Self-checking bench for mult_arbiter. A behavioural multiplier stands in
// for the datapath: it loads B on mul_ClearA_LoadB and, while mul_Run is
// high, presents the signed product of mul_Sw and B on mul_Aval/mul_Bval.
// Tie expectations follow MULT_ARB_RR_EN when the bench is built with it.
// ----------------------------------------------------------------------------
module tb_mult_arbiter;
    import mult_arb_pkg::*;

    localparam int unsigned MC = 18;

    logic Clk;
    logic Reset;

    mult_arbiter_if bus ();

    mult_arbiter #(.MUL_CYCLES(MC)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural multiplier datapath
    logic [7:0]  m_b;
    logic [15:0] m_prod;

    initial begin
        m_b    = 8'h00;
        m_prod = 16'h0000;
    end

    always @(posedge Clk) begin
        if (bus.mul_ClearA_LoadB) begin
            m_b    <= bus.mul_Sw;
            m_prod <= 16'h0000;
        end else if (bus.mul_Run) begin
            m_prod <= 16'($signed(bus.mul_Sw) * $signed(m_b));
        end
    end

    assign bus.mul_Aval = m_prod[15:8];
    assign bus.mul_Bval = m_prod[7:0];

    // done[1] pulse counter
    int n_done1;
    initial n_done1 = 0;
    always @(posedge Clk) begin
        if (bus.done[1]) n_done1 <= n_done1 + 1;
    end

    int n_chk;
    int n_fail;

    typedef struct {
        logic [1:0]  req;
        logic [7:0]  a0;
        logic [7:0]  b0;
        logic [7:0]  a1;
        logic [7:0]  b1;
        logic [1:0]  gnt;
        logic [15:0] res;
    } vec_t;

    vec_t vecs [4];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Called at an IDLE cycle with req already applied; returns at the IDLE
    // cycle that follows RELEASE.
    task automatic run_op(input logic [1:0] eg, input logic [7:0] ea, input logic [7:0] eb,
                          input logic [15:0] er, input bit disturb);
        int bad;
        chk("idle_gnt", 32'(bus.gnt), 32'd0);
        tick();
        chk("loadb_strobes", 32'({bus.mul_ClearA_LoadB, bus.mul_Run}), 32'd2);
        chk("loadb_sw", 32'(bus.mul_Sw), 32'(eb));
        chk("loadb_gnt", 32'(bus.gnt), 32'(eg));
        tick();
        chk("wait_strobes", 32'({bus.mul_ClearA_LoadB, bus.mul_Run}), 32'd0);
        chk("wait_sw", 32'(bus.mul_Sw), 32'(eb));
        bad = 0;
        for (int i = 0; i < int'(MC); i++) begin
            tick();
            if (!(bus.mul_Run === 1'b1 && bus.mul_ClearA_LoadB === 1'b0 && bus.mul_Sw === ea
                  && bus.gnt === eg && bus.done === 2'b00)) bad++;
            if (disturb && i == 4) begin
                bus.a0  = 8'hC3;
                bus.b0  = 8'h5A;
                bus.req = 2'b00;
            end
        end
        chk("run_bad_cycles", 32'(bad), 32'd0);
        tick();
        chk("release_done", 32'(bus.done), 32'(eg));
        chk("release_run", 32'(bus.mul_Run), 32'd0);
        chk("release_gnt", 32'(bus.gnt), 32'(eg));
        chk("release_result", 32'(bus.result), 32'(er));
        tick();
        chk("after_done", 32'(bus.done), 32'd0);
        chk("after_gnt", 32'(bus.gnt), 32'd0);
        chk("after_result", 32'(bus.result), 32'(er));
    endtask

    initial begin
        int d1_start;
        int ndone;
        logic [1:0] tie_g [4];

        n_chk  = 0;
        n_fail = 0;

        vecs[0] = '{req: 2'b01, a0: 8'h07, b0: 8'hFD, a1: 8'h11, b1: 8'h22,
                    gnt: 2'b01, res: 16'hFFEB};
        vecs[1] = '{req: 2'b01, a0: 8'h80, b0: 8'h80, a1: 8'h33, b1: 8'h44,
                    gnt: 2'b01, res: 16'h4000};
        vecs[2] = '{req: 2'b10, a0: 8'h55, b0: 8'h66, a1: 8'h05, b1: 8'h06,
                    gnt: 2'b10, res: 16'h001E};
        vecs[3] = '{req: 2'b10, a0: 8'h11, b0: 8'h22, a1: 8'hFF, b1: 8'h7F,
                    gnt: 2'b10, res: 16'hFF81};

`ifdef MULT_ARB_RR_EN
        tie_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        tie_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif

        // Reset state
        Reset   = 1'b1;
        bus.req = 2'b00;
        bus.a0  = 8'h00;
        bus.b0  = 8'h00;
        bus.a1  = 8'h00;
        bus.b1  = 8'h00;
        repeat (3) tick();
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_sw", 32'(bus.mul_Sw), 32'd0);
        chk("rst_clr", 32'(bus.mul_ClearA_LoadB), 32'd0);
        chk("rst_run", 32'(bus.mul_Run), 32'd0);
        Reset = 1'b0;
        repeat (3) tick();
        chk("idle_no_req_gnt", 32'(bus.gnt), 32'd0);
        chk("idle_no_req_sw", 32'(bus.mul_Sw), 32'd0);

        // Single-requester table
        foreach (vecs[k]) begin
            bus.req = vecs[k].req;
            bus.a0  = vecs[k].a0;
            bus.b0  = vecs[k].b0;
            bus.a1  = vecs[k].a1;
            bus.b1  = vecs[k].b1;
            run_op(vecs[k].gnt,
                   (vecs[k].gnt == 2'b01) ? vecs[k].a0 : vecs[k].a1,
                   (vecs[k].gnt == 2'b01) ? vecs[k].b0 : vecs[k].b1,
                   vecs[k].res, 1'b0);
            bus.req = 2'b00;
            tick();
        end

        // Reset during RUN cycle 5 aborts without a done pulse
        bus.req = 2'b01;
        bus.a0  = 8'h07;
        bus.b0  = 8'hFD;
        tick();
        tick();
        repeat (5) tick();
        chk("abort_pre_run", 32'(bus.mul_Run), 32'd1);
        Reset   = 1'b1;
        bus.req = 2'b00;
        tick();
        chk("abort_run", 32'(bus.mul_Run), 32'd0);
        chk("abort_gnt", 32'(bus.gnt), 32'd0);
        chk("abort_result", 32'(bus.result), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        Reset = 1'b0;
        ndone = 0;
        repeat (30) begin
            tick();
            if (bus.done !== 2'b00) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);

        // Tie held across four operations, starting from the reset pointer
        d1_start = n_done1;
        bus.req  = 2'b11;
        bus.a0   = 8'h03;
        bus.b0   = 8'h04;
        bus.a1   = 8'hFE;
        bus.b1   = 8'h05;
        for (int k = 0; k < 4; k++) begin
            run_op(tie_g[k],
                   (tie_g[k] == 2'b01) ? 8'h03 : 8'hFE,
                   (tie_g[k] == 2'b01) ? 8'h04 : 8'h05,
                   (tie_g[k] == 2'b01) ? 16'h000C : 16'hFFF6, 1'b0);
        end
        bus.req = 2'b00;
        tick();
`ifdef MULT_ARB_RR_EN
        chk("tie_done1_count", 32'(n_done1 - d1_start), 32'd2);
`else
        chk("tie_done1_count", 32'(n_done1 - d1_start), 32'd0);
`endif

        // Operand change and req drop mid-RUN
        bus.req = 2'b01;
        bus.a0  = 8'h09;
        bus.b0  = 8'h0B;
        run_op(2'b01, 8'h09, 8'h0B, 16'h0063, 1'b1);
        tick();
        chk("dropped_stays_idle", 32'(bus.gnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 The block SHALL have parameter MUL_CYCLES, default 18: number of cycles Run is held per operation.
REQ-002 The block SHALL have port Clk, input, 1, system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1, synchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 2, per-requester request level, bit i = requester i.
REQ-005 The block SHALL have ports a0, b0, a1, b1, input, 8 each, operands per requester: a = multiplicand, b = multiplier.
REQ-006 The block SHALL have port gnt, output, 2, one-hot grant, held for the whole operation.
REQ-007 The block SHALL have port done, output, 2, one-cycle pulse to the granted requester when result is valid.
REQ-008 The block SHALL have port result, output, 16, signed product, held until the next capture.
REQ-009 The block SHALL have ports mul_Sw (output, 8), mul_ClearA_LoadB (output, 1) and mul_Run (output, 1), driving the multiplier datapath.
REQ-010 The block SHALL have ports mul_Aval and mul_Bval, input, 8 each, multiplier upper/lower product halves.

Function
REQ-011 The FSM SHALL have states IDLE, LOADB, LOADB_WAIT, RUN, RELEASE.
REQ-012 IDLE: if any req bit is high, the block SHALL select a winner, latch its a/b and index, and go to LOADB; otherwise stay in IDLE.
REQ-013 LOADB (1 cycle): mul_Sw = latched b, mul_ClearA_LoadB = 1, then the FSM SHALL go to LOADB_WAIT.
REQ-014 LOADB_WAIT (1 cycle): mul_Sw = latched b, all strobes 0, then the FSM SHALL go to RUN.
REQ-015 RUN: mul_Sw = latched a and mul_Run = 1 for exactly MUL_CYCLES cycles, counted by an internal counter cleared on RUN entry.
REQ-016 On the clock edge ending the last RUN cycle, result SHALL load {mul_Aval, mul_Bval} and the FSM SHALL go to RELEASE.
REQ-017 RELEASE (1 cycle): mul_Run = 0 and done[winner] = 1; the FSM SHALL then go to IDLE.
REQ-018 gnt[winner] SHALL be 1 from LOADB through RELEASE inclusive, and 0 in IDLE.
REQ-019 mul_Sw SHALL be 0 in IDLE; mul_ClearA_LoadB and mul_Run SHALL never be high in the same cycle.
REQ-020 One operation SHALL take exactly 3 + MUL_CYCLES cycles from LOADB entry to IDLE re-entry, with a minimum of one IDLE cycle between operations.
REQ-021 Operands SHALL be latched only at the IDLE-to-LOADB edge; operand changes during an operation SHALL be ignored.
REQ-022 If req drops mid-operation, the operation SHALL complete and done SHALL still pulse.
REQ-023 A requester holding req high after its done pulse SHALL be treated as a new request.
REQ-024 done SHALL be 0 in every state except RELEASE.

Reset
REQ-025 Reset SHALL force IDLE and clear gnt, done, result, mul_Sw, mul_ClearA_LoadB, mul_Run and the RUN counter to 0.
REQ-026 Reset SHALL set the last-served pointer to 1, so requester 0 wins the first tie.
REQ-027 Reset during any state SHALL abort the operation with no done pulse; mul_Run SHALL be 0 in the following cycle.

Configuration
REQ-028 With MULT_ARB_RR_EN defined, arbitration SHALL be round-robin: on a tie, the requester not served last wins, and the pointer updates at grant.
REQ-029 Without MULT_ARB_RR_EN, arbitration SHALL be fixed priority with requester 0 always winning ties, and no pointer register SHALL exist.
REQ-030 With a single requester, both modes SHALL grant identically.

Structure
REQ-031 Package mult_arb_pkg SHALL hold the state enum type, the operand/result width constants (8, 16) and the default MUL_CYCLES.
REQ-032 Winner selection SHALL live in sub-module mult_arb_grant (inputs req, pointer; output one-hot winner), with RR logic under the macro.

Verification
REQ-033 The bench SHALL cover: req=01, a0=8'h07, b0=8'hFD -> mul_ClearA_LoadB high 1 cycle with mul_Sw=FD; mul_Run high 18 cycles with mul_Sw=07; done=01 at cycle 22; result=16'hFFEB.
REQ-034 The bench SHALL cover: req=11 held, MULT_ARB_RR_EN defined -> grants alternate 01,10,01,10 across 4 operations, each ending in a correctly targeted done pulse.
REQ-035 The bench SHALL cover: req=11 held, macro undefined -> gnt=01 every operation, done[1] never asserted.
REQ-036 The bench SHALL cover: Reset asserted on RUN cycle 5 -> next cycle mul_Run=0, gnt=00, result=0, and no done pulse.
REQ-037 The bench SHALL cover: a0 changed and req0 dropped during RUN -> result uses the latched operands and done[0] still pulses.
REQ-038 The bench SHALL cover: a0=8'h80, b0=8'h80 -> result=16'h4000 (signed -128 × -128), confirming full-width capture.
